scrambler15: RTL and testbench



---
 rtl/scrambler15_pkg.sv | 26 ++
 rtl/scrambler15.sv | 52 +++++
 tb/tb_scrambler15.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/scrambler15_pkg.sv
// -----------------------------------------------------------------------------
// scrambler_pkg
//   Shared definitions for the PRBS15 whitening scrambler.
//   - SCR_WIDTH / SCR_TAP_HI / SCR_TAP_LO : LFSR geometry, x^15 + x^14 + 1
//   - SCR_PERIOD                          : sequence length for a nonzero seed
//   - scr_state_t                         : one LFSR state
//   - scr_step()                          : one Fibonacci LFSR advance
// -----------------------------------------------------------------------------
package scrambler_pkg;

   localparam int SCR_WIDTH  = 15;
   localparam int SCR_TAP_HI = 14;
   localparam int SCR_TAP_LO = 13;
   localparam int SCR_PERIOD = 32767;

   typedef logic [SCR_WIDTH-1:0] scr_state_t;

   // Shift left, drop the MSB, insert the XOR of the two taps at bit 0.
   // The all-zero state maps to itself (lock-up); callers must seed nonzero.
   function automatic scr_state_t scr_step(input scr_state_t s);
      logic fb;
      fb = s[SCR_TAP_HI] ^ s[SCR_TAP_LO];
      return {s[SCR_WIDTH-2:0], fb};
   endfunction

endpackage : scrambler_pkg

// File: rtl/scrambler15.sv
// -----------------------------------------------------------------------------
// scrambler15
//   Single-step PRBS15 LFSR register. Every rising edge captures one LFSR
//   advance of initial_value into dout. The parent closes the loop by wiring
//   dout back to initial_value, giving a free-running maximal-length sequence.
//
// Ports
//   clk           in   1      rising-edge clock
//   rst           in   1      asynchronous active-high reset, forces dout = 0
//   initial_value in   WIDTH  current LFSR state or seed, sampled every edge
//   dout          out  WIDTH  registered next LFSR state
//
// No enable and no handshake: the register advances on every clock. There is
// no escape from the all-zero state; the parent must present a nonzero seed
// for at least one edge after reset before closing the loop.
// -----------------------------------------------------------------------------
module scrambler15
   import scrambler_pkg::*;
#(
   parameter int WIDTH  = SCR_WIDTH,
   parameter int TAP_HI = SCR_TAP_HI,
   parameter int TAP_LO = SCR_TAP_LO
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] initial_value,
   output logic [WIDTH-1:0] dout
);

   // Only the x^15 + x^14 + 1 geometry is implemented by scr_step.
   if (WIDTH != SCR_WIDTH || TAP_HI != SCR_TAP_HI || TAP_LO != SCR_TAP_LO) begin : g_bad_geometry
      $error("scrambler15: only WIDTH=15, TAP_HI=14, TAP_LO=13 is supported");
   end

   scr_state_t dout_d;
   scr_state_t dout_q;

   always_comb begin
      dout_d = scr_step(scr_state_t'(initial_value));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule : scrambler15

// File: tb/tb_scrambler15.sv
// -----------------------------------------------------------------------------
// tb_scrambler15
//   Self-checking bench for scrambler15. The reference next-state is computed
//   with plain integer arithmetic (doubling modulo 2^15 plus the XOR of the two
//   top bits) and a visited-state array tracks the closed-loop period.
// -----------------------------------------------------------------------------
module tb_scrambler15;

   logic        clk;
   logic        rst;
   logic [14:0] initial_value;
   logic [14:0] dout;

   int n_tests;
   int n_fail;

   scrambler15 dut (
      .clk           (clk),
      .rst           (rst),
      .initial_value (initial_value),
      .dout          (dout)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   function automatic int ref_next(input int s);
      int top, nxt;
      top = ((s / 16384) % 2) ^ ((s / 8192) % 2);
      nxt = (s * 2) % 32768 + top;
      return nxt;
   endfunction

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: dout=0x%04h expected=0x%04h", name, act, exp);
      end
   endtask

   // Advance to the next falling edge (drive/sample point, away from posedge).
   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic [14:0] in_val;
      logic [14:0] exp_val;
   } vec_t;

   vec_t vecs[8];
   logic [14:0] closed_exp[8];
   bit          seen[32768];

   initial begin
      logic [14:0] seed;
      logic [14:0] exp_v;
      int          distinct;
      int          first_return;
      n_tests = 0;
      n_fail  = 0;

      // ------------------------------------------------ vector table
      vecs[0] = '{15'h00A9, 15'h0152};
      vecs[1] = '{15'h0000, 15'h0000};
      vecs[2] = '{15'h4000, 15'h0001};
      vecs[3] = '{15'h6000, 15'h4000};
      vecs[4] = '{15'h7FFF, 15'h7FFE};
      vecs[5] = '{15'h2000, 15'h4001};
      vecs[6] = '{15'h0001, 15'h0002};
      vecs[7] = '{15'h2A40, 15'h5481};
      closed_exp = '{15'h0152, 15'h02A4, 15'h0548, 15'h0A90,
                     15'h1520, 15'h2A40, 15'h5481, 15'h2903};

      // ------------------------------------------------ reset
      rst = 1'b1;
      initial_value = 15'h00A9;
      #1;
      check("reset_immediate", dout, 15'h0000);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         check("reset_held", dout, 15'h0000);
      end

      // ------------------------------------------------ open-loop single step
      rst = 1'b0;
      next_cycle();
      check("open_loop_first", dout, 15'h0152);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         check("open_loop_hold", dout, 15'h0152);
      end

      // ------------------------------------------------ table vectors
      foreach (vecs[i]) begin
         initial_value = vecs[i].in_val;
         next_cycle();
         check($sformatf("vec%0d", i), dout, vecs[i].exp_val);
      end

      // ------------------------------------------------ random vs model
      for (int i = 0; i < 200; i++) begin
         initial_value = 15'($urandom_range(0, 32767));
         exp_v = 15'(ref_next(int'(initial_value)));
         next_cycle();
         check("random_step", dout, exp_v);
      end

      // ------------------------------------------------ closed loop from 0x00A9
      initial_value = 15'h00A9;
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         check($sformatf("closed_seq%0d", i), dout, closed_exp[i]);
         initial_value = dout;
      end

      // ------------------------------------------------ full period
      seed = 15'h00A9;
      foreach (seen[i]) seen[i] = 1'b0;
      distinct = 0;
      first_return = 0;
      exp_v = seed;
      initial_value = seed;
      for (int k = 1; k <= 32767; k++) begin
         next_cycle();
         exp_v = 15'(ref_next(int'(exp_v)));
         n_tests++;
         if (dout !== exp_v || dout == 15'h0000 || seen[dout]) begin
            n_fail++;
            $display("FAIL period_step%0d: dout=0x%04h expected=0x%04h seen=%0b",
                     k, dout, exp_v, seen[dout]);
         end else begin
            seen[dout] = 1'b1;
            distinct++;
         end
         if (dout == seed && first_return == 0) first_return = k;
         initial_value = dout;
      end
      n_tests++;
      if (distinct != 32767) begin
         n_fail++;
         $display("FAIL period_distinct: count=%0d expected=32767", distinct);
      end
      n_tests++;
      if (first_return != 32767) begin
         n_fail++;
         $display("FAIL period_return: first_return=%0d expected=32767", first_return);
      end

      // ------------------------------------------------ lock-up
      initial_value = 15'h0000;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         check("lockup", dout, 15'h0000);
         initial_value = dout;
      end

      // ------------------------------------------------ reset mid-run
      initial_value = 15'h1234;
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         initial_value = dout;
      end
      check("pre_reset_nonzero_run", dout, 15'(ref_next(ref_next(ref_next(ref_next(32'h1234))))));
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_between_edges", dout, 15'h0000);
      next_cycle();
      check("async_reset_held", dout, 15'h0000);
      initial_value = 15'h4000;
      rst = 1'b0;
      next_cycle();
      check("post_reset_seed", dout, 15'h0001);
      initial_value = dout;
      next_cycle();
      check("post_reset_closed", dout, 15'h0002);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $finish;
   end

endmodule : tb_scrambler15
